// File: rtl/rst_clken_pkg.sv
// rst_clken_pkg: shared types, constants and parameter check for rst_clken_seq
package rst_clken_pkg;
  typedef enum logic [1:0] {ST_RESET, ST_RELEASE, ST_HOLD, ST_RUN} state_t;
  localparam int SYNC_DEPTH = 2;
  function automatic bit params_ok(input int n_rst, input int div_w);
    return n_rst >= 1 && n_rst <= 16 && div_w >= 1;
  endfunction
endpackage

// File: rtl/clken_div.sv
// clken_div: runtime-programmable clock-enable divider with glitch-free ratio change
//   clk, rst_n      : clock, async active-low reset
//   i_clr           : synchronous clear while the sequencer is in internal reset
//   i_div_sel/upd   : new divide select (ratio = sel+1) and its one-cycle update strobe
//   o_clk_en        : one-cycle-high enable per period
//   o_div_ack       : pulse in the first cycle using the new ratio
module clken_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div_sel,
  input  logic             i_div_upd,
  output logic             o_clk_en,
  output logic             o_div_ack
);
  logic [DIV_W:0]   r_ratio;
  logic [DIV_W:0]   r_pend;
  logic [DIV_W-1:0] r_cnt;
  logic             r_pf;
  logic             r_ack;
  logic             w_wrap;
  assign w_wrap    = {1'b0, r_cnt} == r_ratio - 1'b1;
  assign o_clk_en  = !i_clr && r_cnt == '0;
  assign o_div_ack = r_ack;
  // A pending ratio is only taken at a wrap, so the period in flight always completes.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ratio <= 1;
      r_pend  <= 1;
      r_cnt   <= '0;
      r_pf    <= 1'b0;
      r_ack   <= 1'b0;
    end else if (i_clr) begin
      r_ratio <= 1;
      r_pend  <= 1;
      r_cnt   <= '0;
      r_pf    <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_wrap && r_pf;
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap && r_pf) r_ratio <= r_pend;
      r_pf <= i_div_upd || (r_pf && !w_wrap);
      if (i_div_upd) r_pend <= {1'b0, i_div_sel} + 1'b1;
    end
endmodule

// File: rtl/rst_clken_seq.sv
// rst_clken_seq: ordered reset-domain sequencer with software reset and clock-enable divider
//   clk, rst_n       : clock, async active-low reset (release synchronised internally)
//   srst_req         : level software reset request
//   stage_dly        : per-stage delay, sampled at every counter reload
//   div_sel/div_upd  : divide select (ratio = sel+1) and update strobe
//   rst_n_o          : sequenced active-low resets, bit 0 released first
//   clk_en, div_ack  : divided enable, ratio-change acknowledge
//   busy             : high outside RUN
module rst_clken_seq
  import rst_clken_pkg::*;
#(
  parameter int N_RST = 4,
  parameter int DLY_W = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst_req,
  input  logic [DLY_W-1:0] stage_dly,
  input  logic [DIV_W-1:0] div_sel,
  input  logic             div_upd,
  output logic [N_RST-1:0] rst_n_o,
  output logic             clk_en,
  output logic             div_ack,
  output logic             busy
);
  if (!params_ok(N_RST, DIV_W)) begin : g_bad_params
    $error("rst_clken_seq: N_RST must be 1..16 and DIV_W at least 1");
  end
  state_t                  r_state;
  logic [SYNC_DEPTH-2:0]   r_sync;
  logic [DLY_W-1:0]        r_dcnt;
  logic [N_RST-1:0]        r_rst;
  logic [N_RST-1:0]        w_nxt;
  // Resets release as a thermometer: each stage adds the next higher bit.
  assign w_nxt   = (r_rst << 1) | N_RST'(1);
  assign rst_n_o = r_rst;
  assign busy    = r_state != ST_RUN;
  // The state register acts as the final synchroniser stage, so leaving
  // RESET happens on the SYNC_DEPTH-th edge after rst_n releases.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else r_sync <= (SYNC_DEPTH-1)'({r_sync, 1'b1});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_RESET;
      r_dcnt  <= '0;
      r_rst   <= '0;
    end else if (r_state == ST_RESET) begin
      if (r_sync[SYNC_DEPTH-2]) begin
        r_state <= ST_RELEASE;
        r_dcnt  <= stage_dly;
      end
    end else if (srst_req) begin
      r_state <= ST_HOLD;
      r_dcnt  <= stage_dly;
      r_rst   <= '0;
    end else if (r_state != ST_RUN && r_dcnt != '0) begin
      r_dcnt <= r_dcnt - 1'b1;
    end else if (r_state == ST_RELEASE) begin
      r_rst  <= w_nxt;
      r_dcnt <= stage_dly;
      if (w_nxt[N_RST-1]) r_state <= ST_RUN;
    end else if (r_state == ST_HOLD) begin
      r_state <= ST_RELEASE;
      r_dcnt  <= stage_dly;
    end
  clken_div #(.DIV_W(DIV_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state == ST_RESET),
    .i_div_sel (div_sel),
    .i_div_upd (div_upd),
    .o_clk_en  (clk_en),
    .o_div_ack (div_ack)
  );
endmodule
